// File: rtl/tictactoe_turn_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tictactoe_turn_ctrl                                       |
// | Turn sequencer and board write-port arbiter for tic-tac-toe.       |
// | Accepts human and AI moves, checks turn/range/occupancy, issues    |
// | single-cycle board writes and tracks win, draw and move count.     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tictactoe_turn_ctrl #(
   parameter int AI_TIMEOUT = 16
) (
   input  logic       ph1,
   input  logic       reset,
   input  logic       new_game,
   input  logic       hum_req,
   input  logic [1:0] hum_xoro,
   input  logic [1:0] hum_row,
   input  logic [1:0] hum_col,
   output logic       hum_ack,
   input  logic       ai_en,
   output logic       ai_start,
   input  logic       ai_valid,
   input  logic [1:0] ai_row,
   input  logic [1:0] ai_col,
   output logic [1:0] chk_row,
   output logic [1:0] chk_col,
   input  logic       occ,
   input  logic [1:0] win,
   output logic       wr_en,
   output logic [1:0] wr_xoro,
   output logic [1:0] wr_row,
   output logic [1:0] wr_col,
   output logic       clr,
   output logic       err,
   output logic [1:0] err_code,
   output logic [1:0] turn,
   output logic [3:0] move_cnt,
   output logic       game_over,
   output logic [1:0] result
);

   typedef enum logic [2:0] {
      S_TURN    = 3'd0,
      S_AI_WAIT = 3'd1,
      S_CHECK   = 3'd2,
      S_WRITE   = 3'd3,
      S_SETTLE  = 3'd4,
      S_OVER    = 3'd5
   } state_t;

   localparam logic [7:0] TIMER_LAST = 8'(AI_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [1:0] turn_q, turn_d;
   logic [3:0] move_cnt_q, move_cnt_d;
   logic [1:0] mv_xoro_q, mv_xoro_d;
   logic [1:0] mv_row_q, mv_row_d;
   logic [1:0] mv_col_q, mv_col_d;
   logic [1:0] wr_xoro_q, wr_xoro_d;
   logic [1:0] wr_row_q, wr_row_d;
   logic [1:0] wr_col_q, wr_col_d;
   logic       wr_en_q, wr_en_d;
   logic       hum_ack_q, hum_ack_d;
   logic       ai_start_q, ai_start_d;
   logic       clr_q, clr_d;
   logic       err_q, err_d;
   logic [1:0] err_code_q, err_code_d;
   logic       game_over_q, game_over_d;
   logic [1:0] result_q, result_d;
   logic [7:0] timer_q, timer_d;

   // Next-state and registered-output computation; new_game overrides everything.
   always_comb begin
      state_d     = state_q;
      turn_d      = turn_q;
      move_cnt_d  = move_cnt_q;
      mv_xoro_d   = mv_xoro_q;
      mv_row_d    = mv_row_q;
      mv_col_d    = mv_col_q;
      wr_xoro_d   = wr_xoro_q;
      wr_row_d    = wr_row_q;
      wr_col_d    = wr_col_q;
      wr_en_d     = 1'b0;
      hum_ack_d   = 1'b0;
      ai_start_d  = 1'b0;
      clr_d       = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      game_over_d = game_over_q;
      result_d    = result_q;
      timer_d     = timer_q;

      if (new_game) begin
         clr_d       = 1'b1;
         state_d     = S_TURN;
         turn_d      = 2'b01;
         move_cnt_d  = 4'd0;
         result_d    = 2'b00;
         game_over_d = 1'b0;
      end else begin
         case (state_q)
            S_TURN: begin
               if (turn_q == 2'b10 && ai_en) begin
                  ai_start_d = 1'b1;
                  timer_d    = 8'd0;
                  state_d    = S_AI_WAIT;
                  if (hum_req) begin
                     err_d      = 1'b1;
                     err_code_d = 2'b01;
                  end
               end else if (hum_req) begin
                  if (hum_xoro != turn_q) begin
                     err_d      = 1'b1;
                     err_code_d = 2'b01;
                  end else if (hum_row == 2'd3 || hum_col == 2'd3) begin
                     err_d      = 1'b1;
                     err_code_d = 2'b10;
                  end else begin
                     mv_xoro_d = hum_xoro;
                     mv_row_d  = hum_row;
                     mv_col_d  = hum_col;
                     hum_ack_d = 1'b1;
                     state_d   = S_CHECK;
                  end
               end
            end
            S_AI_WAIT: begin
               timer_d = timer_q + 8'd1;
               if (ai_valid) begin
                  if (ai_row == 2'd3 || ai_col == 2'd3) begin
                     err_d      = 1'b1;
                     err_code_d = 2'b10;
                     state_d    = S_TURN;
                  end else begin
                     mv_xoro_d = 2'b10;
                     mv_row_d  = ai_row;
                     mv_col_d  = ai_col;
                     state_d   = S_CHECK;
                  end
               end else if (timer_q == TIMER_LAST) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b00;
                  state_d    = S_TURN;
               end
               // A turn violation outranks any coordinate/timeout code this cycle
               if (hum_req) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b01;
               end
            end
            S_CHECK: begin
               if (occ) begin
                  err_d      = 1'b1;
                  err_code_d = 2'b11;
                  state_d    = S_TURN;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_xoro_d = mv_xoro_q;
                  wr_row_d  = mv_row_q;
                  wr_col_d  = mv_col_q;
                  state_d   = S_WRITE;
               end
            end
            S_WRITE: begin
               move_cnt_d = (move_cnt_q == 4'd9) ? 4'd9 : move_cnt_q + 4'd1;
               state_d    = S_SETTLE;
            end
            S_SETTLE: begin
               if (win != 2'b00) begin
                  result_d    = win;
                  game_over_d = 1'b1;
                  state_d     = S_OVER;
               end else if (move_cnt_q == 4'd9) begin
                  result_d    = 2'b11;
                  game_over_d = 1'b1;
                  state_d     = S_OVER;
               end else begin
                  turn_d  = (turn_q == 2'b01) ? 2'b10 : 2'b01;
                  state_d = S_TURN;
               end
            end
            S_OVER: begin
               state_d = S_OVER;
            end
            default: begin
               state_d = S_TURN;
            end
         endcase
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state_q     <= S_TURN;
         turn_q      <= 2'b01;
         move_cnt_q  <= 4'd0;
         mv_xoro_q   <= 2'b00;
         mv_row_q    <= 2'b00;
         mv_col_q    <= 2'b00;
         wr_xoro_q   <= 2'b00;
         wr_row_q    <= 2'b00;
         wr_col_q    <= 2'b00;
         wr_en_q     <= 1'b0;
         hum_ack_q   <= 1'b0;
         ai_start_q  <= 1'b0;
         clr_q       <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
         game_over_q <= 1'b0;
         result_q    <= 2'b00;
         timer_q     <= 8'd0;
      end else begin
         state_q     <= state_d;
         turn_q      <= turn_d;
         move_cnt_q  <= move_cnt_d;
         mv_xoro_q   <= mv_xoro_d;
         mv_row_q    <= mv_row_d;
         mv_col_q    <= mv_col_d;
         wr_xoro_q   <= wr_xoro_d;
         wr_row_q    <= wr_row_d;
         wr_col_q    <= wr_col_d;
         wr_en_q     <= wr_en_d;
         hum_ack_q   <= hum_ack_d;
         ai_start_q  <= ai_start_d;
         clr_q       <= clr_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         game_over_q <= game_over_d;
         result_q    <= result_d;
         timer_q     <= timer_d;
      end
   end

   assign hum_ack   = hum_ack_q;
   assign ai_start  = ai_start_q;
   assign chk_row   = mv_row_q;
   assign chk_col   = mv_col_q;
   assign wr_en     = wr_en_q;
   assign wr_xoro   = wr_xoro_q;
   assign wr_row    = wr_row_q;
   assign wr_col    = wr_col_q;
   assign clr       = clr_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign turn      = turn_q;
   assign move_cnt  = move_cnt_q;
   assign game_over = game_over_q;
   assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_tictactoe_turn_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_tictactoe_turn_ctrl                                    |
// | Directed self-checking bench for tictactoe_turn_ctrl.              |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_tictactoe_turn_ctrl;

   logic       ph1 = 1'b0;
   logic       reset;
   logic       new_game;
   logic       hum_req;
   logic [1:0] hum_xoro, hum_row, hum_col;
   logic       hum_ack;
   logic       ai_en;
   logic       ai_start;
   logic       ai_valid;
   logic [1:0] ai_row, ai_col;
   logic [1:0] chk_row, chk_col;
   logic       occ;
   logic [1:0] win;
   logic       wr_en;
   logic [1:0] wr_xoro, wr_row, wr_col;
   logic       clr, err;
   logic [1:0] err_code, turn;
   logic [3:0] move_cnt;
   logic       game_over;
   logic [1:0] result;

   int total = 0;
   int bad   = 0;

   tictactoe_turn_ctrl #(.AI_TIMEOUT(16)) dut (
      .ph1(ph1), .reset(reset), .new_game(new_game),
      .hum_req(hum_req), .hum_xoro(hum_xoro), .hum_row(hum_row), .hum_col(hum_col),
      .hum_ack(hum_ack), .ai_en(ai_en), .ai_start(ai_start), .ai_valid(ai_valid),
      .ai_row(ai_row), .ai_col(ai_col), .chk_row(chk_row), .chk_col(chk_col),
      .occ(occ), .win(win), .wr_en(wr_en), .wr_xoro(wr_xoro), .wr_row(wr_row),
      .wr_col(wr_col), .clr(clr), .err(err), .err_code(err_code), .turn(turn),
      .move_cnt(move_cnt), .game_over(game_over), .result(result)
   );

   always #5 ph1 = ~ph1;

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge ph1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete human move: request, ack, write, settle, back to TURN.
   task automatic do_move(input logic [1:0] xo, input logic [1:0] r, input logic [1:0] c,
                          input logic [1:0] winv);
      hum_req = 1'b1; hum_xoro = xo; hum_row = r; hum_col = c;
      tick();
      hum_req = 1'b0;
      chk("mv_ack", {7'd0, hum_ack}, 8'd1);
      chk("mv_noerr", {7'd0, err}, 8'd0);
      tick();
      chk("mv_wr", {1'b0, wr_en, wr_xoro, wr_row, wr_col}, {1'b0, 1'b1, xo, r, c});
      win = winv;
      tick();
      chk("mv_wr_off", {7'd0, wr_en}, 8'd0);
      tick();
      win = 2'b00;
   endtask

   logic saw_err;
   logic [1:0] dr_r [9];
   logic [1:0] dr_c [9];

   initial begin
      reset = 1'b0; new_game = 1'b0; hum_req = 1'b0; hum_xoro = 2'b00;
      hum_row = 2'd0; hum_col = 2'd0; ai_en = 1'b0; ai_valid = 1'b0;
      ai_row = 2'd0; ai_col = 2'd0; occ = 1'b0; win = 2'b00;
      dr_r = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
      dr_c = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
      tick(); tick();
      reset = 1'b1;
      tick();

      // Reset state
      chk("rst_turn", {6'd0, turn}, 8'h01);
      chk("rst_pulses", {2'd0, hum_ack, ai_start, wr_en, clr, err, game_over}, 8'd0);
      chk("rst_cnt_res", {2'd0, move_cnt, result}, 8'd0);
      chk("rst_code_chk", {2'd0, err_code, chk_row, chk_col}, 8'd0);
      chk("rst_wrdata", {2'd0, wr_xoro, wr_row, wr_col}, 8'd0);

      // O requests on X's turn
      hum_req = 1'b1; hum_xoro = 2'b10; hum_row = 2'd0; hum_col = 2'd0;
      tick();
      hum_req = 1'b0;
      chk("wrong_turn", {5'd0, err, err_code}, 8'b101);
      chk("wrong_turn_noack", {7'd0, hum_ack}, 8'd0);
      tick();
      chk("err_one_cycle", {7'd0, err}, 8'd0);

      // Bad coordinate
      hum_req = 1'b1; hum_xoro = 2'b01; hum_row = 2'd3; hum_col = 2'd1;
      tick();
      hum_req = 1'b0;
      chk("bad_coord", {4'd0, hum_ack, err, err_code}, 8'b0110);
      tick();

      // Occupied cell
      hum_req = 1'b1; hum_xoro = 2'b01; hum_row = 2'd0; hum_col = 2'd0;
      tick();
      hum_req = 1'b0; occ = 1'b1;
      chk("occ_ack", {7'd0, hum_ack}, 8'd1);
      tick();
      occ = 1'b0;
      chk("occ_err", {4'd0, wr_en, err, err_code}, 8'b0111);
      tick();
      chk("occ_nowr", {1'b0, wr_en, turn, move_cnt}, {1'b0, 1'b0, 2'b01, 4'd0});

      // X at (0,0)
      do_move(2'b01, 2'd0, 2'd0, 2'b00);
      chk("x00_state", {2'd0, turn, move_cnt}, {2'd0, 2'b10, 4'd1});

      // AI move at (1,1)
      ai_en = 1'b1;
      tick();
      chk("ai_start", {7'd0, ai_start}, 8'd1);
      ai_valid = 1'b1; ai_row = 2'd1; ai_col = 2'd1;
      tick();
      ai_valid = 1'b0;
      chk("ai_start_pulse", {7'd0, ai_start}, 8'd0);
      tick();
      chk("ai_wr", {1'b0, wr_en, wr_xoro, wr_row, wr_col}, {1'b0, 1'b1, 2'b10, 2'd1, 2'd1});
      tick(); tick();
      chk("ai_state", {2'd0, turn, move_cnt}, {2'd0, 2'b01, 4'd2});

      // X at (0,1), then AI timeout
      do_move(2'b01, 2'd0, 2'd1, 2'b00);
      tick();
      chk("ai_start2", {7'd0, ai_start}, 8'd1);
      saw_err = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         saw_err = saw_err | err;
      end
      chk("tmo_early", {7'd0, saw_err}, 8'd0);
      tick();
      chk("tmo_err", {5'd0, err, err_code}, 8'b100);
      tick();
      chk("tmo_restart", {7'd0, ai_start}, 8'd1);
      ai_valid = 1'b1; ai_row = 2'd2; ai_col = 2'd0;
      tick();
      ai_valid = 1'b0;
      tick();
      chk("ai_wr2", {1'b0, wr_en, wr_xoro, wr_row, wr_col}, {1'b0, 1'b1, 2'b10, 2'd2, 2'd0});
      tick(); tick();
      chk("ai2_state", {2'd0, turn, move_cnt}, {2'd0, 2'b01, 4'd4});
      ai_en = 1'b0;

      // X completes the top row and wins
      do_move(2'b01, 2'd0, 2'd2, 2'b01);
      chk("win", {1'b0, game_over, result, move_cnt}, {1'b0, 1'b1, 2'b01, 4'd5});
      hum_req = 1'b1; hum_xoro = 2'b01; hum_row = 2'd1; hum_col = 2'd2;
      tick(); tick();
      hum_req = 1'b0;
      chk("over_ignore", {6'd0, hum_ack, err}, 8'd0);

      // New game
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      chk("ng_clr", {7'd0, clr}, 8'd1);
      chk("ng_state", {game_over, result, move_cnt, 1'b0}, {1'b0, 2'b00, 4'd0, 1'b0});
      tick();
      chk("ng_clr_pulse", {5'd0, clr, turn}, {5'd0, 1'b0, 2'b01});

      // new_game while in CHECK
      hum_req = 1'b1; hum_xoro = 2'b01; hum_row = 2'd1; hum_col = 2'd1;
      tick();
      hum_req = 1'b0;
      chk("ngc_ack", {7'd0, hum_ack}, 8'd1);
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      chk("ngc_clr", {6'd0, clr, wr_en}, 8'b10);
      tick();
      chk("ngc_nowr", {1'b0, wr_en, turn, move_cnt}, {1'b0, 1'b0, 2'b01, 4'd0});

      // Draw: nine moves, no win
      for (int i = 0; i < 9; i++)
         do_move((i % 2 == 0) ? 2'b01 : 2'b10, dr_r[i], dr_c[i], 2'b00);
      chk("draw", {1'b0, game_over, result, move_cnt}, {1'b0, 1'b1, 2'b11, 4'd9});

      // Reset asserted one cycle before WRITE
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      tick();
      hum_req = 1'b1; hum_xoro = 2'b01; hum_row = 2'd2; hum_col = 2'd2;
      tick();
      hum_req = 1'b0;
      chk("rstw_ack", {7'd0, hum_ack}, 8'd1);
      reset = 1'b0;
      tick();
      chk("rstw_nowr", {1'b0, wr_en, game_over, result, move_cnt[2:0]}, 8'd0);
      reset = 1'b1;
      tick();
      chk("rstw_nowr2", {1'b0, wr_en, turn, move_cnt}, {1'b0, 1'b0, 2'b01, 4'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tictactoe_turn_ctrl.md
# tictactoe_turn_ctrl

Turn sequencer and write-port arbiter for the tic-tac-toe board. It accepts moves from the human input port and from the AI move engine, and checks turn order, coordinate range and cell occupancy. It issues single-cycle writes to the board register file and tracks move count, win and draw to produce the game result.

## Interface
- AI_TIMEOUT, 16: cycles to wait in AI_WAIT for ai_valid before flagging a timeout (2..255).
- ph1  in  1  system clock, rising-edge; the single clock of this block.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- new_game  in  1  synchronous restart pulse; highest priority after reset.
- hum_req  in  1  human move request, level sampled each cycle.
- hum_xoro  in  2  claimed player: 01 = X, 10 = O; 00 and 11 are invalid.
- hum_row, hum_col  in  2  human move coordinates; valid range 0..2.
- hum_ack  out  1  one-cycle pulse when a human move is captured.
- ai_en  in  1  AI plays O; sampled only in TURN.
- ai_start  out  1  one-cycle pulse requesting an AI move.
- ai_valid  in  1  AI move ready, sampled only in AI_WAIT.
- ai_row, ai_col  in  2  AI move coordinates.
- chk_row, chk_col  out  2  board lookup address (registered move).
- occ  in  1  board cell at chk_row/chk_col is occupied; combinational return, same cycle.
- win  in  2  board win status: 00 none, 01 X, 10 O.
- wr_en  out  1  board write strobe.
- wr_xoro, wr_row, wr_col  out  2  board write data and address.
- clr  out  1  one-cycle board-clear pulse.
- err  out  1  one-cycle error pulse.
- err_code  out  2  00 AI timeout, 01 wrong turn, 10 bad coordinate, 11 cell occupied; holds its last value.
- turn  out  2  player to move: 01 X, 10 O.
- move_cnt  out  4  committed moves, 0..9.
- game_over  out  1  game finished.
- result  out  2  01 X won, 10 O won, 11 draw; 00 while playing.

## Operation
- States: TURN, AI_WAIT, CHECK, WRITE, SETTLE, OVER.
- TURN, AI turn (turn=10 and ai_en=1): pulse ai_start, clear the timer, go to AI_WAIT. A hum_req in this case raises err/01.
- TURN, human turn, hum_req=1:
  - hum_xoro≠turn: err/01.
  - Otherwise any row or col = 3: err/10.
  - Otherwise capture xoro/row/col, pulse hum_ack, go to CHECK.
  - On an error the state stays TURN and no hum_ack is issued.
- AI_WAIT:
  - ai_valid=1 with ai_row or ai_col = 3: err/10, return to TURN.
  - ai_valid=1 with valid coordinates: capture (xoro=10), go to CHECK.
  - Timer reaches AI_TIMEOUT−1 with no ai_valid: err/00, return to TURN.
  - TURN re-issues ai_start in each of these return cases.
  - hum_req in AI_WAIT: err/01, state unchanged.
- CHECK: chk_row/chk_col present the captured move.
  - occ=1: err/11, return to TURN (the same player retries).
  - occ=0: go to WRITE.
- WRITE: wr_en=1 with the captured data; move_cnt+1; go to SETTLE.
- SETTLE: sample win.
  - win≠00: go to OVER, result=win.
  - Else move_cnt=9: go to OVER, result=11.
  - Else toggle turn (01↔10), go to TURN.
- OVER: game_over=1. All requests are ignored with no err and no ack. The block stays in OVER until new_game or reset.
- new_game (any state): clr pulses next cycle. State becomes TURN, turn=01, move_cnt=0, result=00, game_over=0. A simultaneous hum_req or ai_valid is dropped.
- Only one error per cycle. Check priority: turn, then coordinate, then occupancy.

## Timing
- Reset values: state TURN, turn=01, every other output 0 (including err_code and chk_row/chk_col).
- Reset asserted mid-move aborts immediately; no wr_en is issued.
- All outputs are registered.
- err, hum_ack, ai_start, wr_en and clr are high for exactly one cycle.
- Human latency: hum_req sampled at edge N gives hum_ack in cycle N+1 and wr_en in cycle N+2. turn updates, or game_over rises, after edge N+3. The next request is accepted at edge N+4.
- AI latency: ai_valid sampled at edge N gives wr_en in cycle N+2.
- wr_xoro, wr_row and wr_col are stable while wr_en=1 and hold afterwards.
- move_cnt saturates at 9 and never wraps.
- An AI timeout fires at exactly AI_TIMEOUT cycles after the ai_start cycle.

## Test plan
- Reset: after reset release, turn=01 and all outputs 0. X at (0,0): hum_ack at cycle +1, wr_en with 01/0/0 at cycle +2, turn=10 at cycle +4.
- Error checks: O requests while turn=01 → err/01. X at (3,1) → err/10. X on an occupied cell (occ=1) → err/11, turn stays 01, no wr_en.
- AI flow: ai_en=1 on O's turn → ai_start. ai_valid with (1,1) → wr_en 10/1/1. Holding ai_valid low for AI_TIMEOUT cycles → err/00, then ai_start again.
- Win: X plays (0,0),(0,1),(0,2) with win=01 returned after the third write → game_over=1, result=01, move_cnt=5 (O moves interleaved). A following hum_req gets no ack and no err.
- Draw: nine valid moves with win=00 throughout → result=11 and move_cnt=9 after the ninth SETTLE.
- Restart: new_game during CHECK → clr pulse, no wr_en, move_cnt=0, turn=01. Reset asserted in WRITE-1 gives no write.
